// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg: shared op encodings, FSM states and counter sizing for mul_div_unit
//   OP_MULT/OP_MULTU/OP_DIV/OP_DIVU : 2-bit operation codes
//   state_t                         : IDLE, CALC, FIX
//   cnt_width(w)                    : step-counter width for a w-bit datapath
package mul_div_unit_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MULT/MULTU/DIV/DIVU engine with architectural HI/LO registers
//   clk, rst      : rising-edge clock, asynchronous active-high reset
//   op_a, op_b    : rs / rt operands, sampled only when a start is accepted
//   op            : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   start         : begin an operation (ignored while busy)
//   mt_hi, mt_lo  : load op_a into HI / LO when idle and not starting
//   hi, lo        : HI/LO registers (product high/low, or remainder/quotient)
//   busy          : operation in flight, stall request to the core
//   done          : one-cycle pulse after HI/LO are written by an operation
module mul_div_unit
   import mul_div_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic [1:0]       op,
   input  logic             start,
   input  logic             mt_hi,
   input  logic             mt_lo,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done
);

   localparam int CW = cnt_width(WIDTH);

   state_t             state, next;
   logic [1:0]         op_q;
   logic [WIDTH-1:0]   a_mag, b_mag, a_raw;
   logic               neg_q, neg_r;
   logic [2*WIDTH-1:0] acc, mul_step, div_step, prod;
   logic [CW-1:0]      cnt, bit_idx;
   logic [WIDTH:0]     trial;
   logic [WIDTH-1:0]   quo, rem, res_hi, res_lo;
   logic               is_div, b_zero, a_bit, sa, sb;

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= next;

   always_comb begin
      next = state;
      next = (state == IDLE) ? (start ? CALC : IDLE) :
             (state == CALC) ? ((cnt == CW'(WIDTH - 1)) ? FIX : CALC) : IDLE;
   end

   assign busy    = state != IDLE;
   assign is_div  = op_q[1];
   assign b_zero  = b_mag == '0;
   // Operand bits are consumed MSB first in both multiply and divide.
   assign bit_idx = CW'(WIDTH - 1) - cnt;
   assign a_bit   = a_mag[bit_idx];
   assign sa      = (op == OP_MULT || op == OP_DIV) && op_a[WIDTH-1];
   assign sb      = (op == OP_MULT || op == OP_DIV) && op_b[WIDTH-1];

   // Multiply: Horner-style shift-add, product accumulates across the full width.
   assign mul_step = {acc[2*WIDTH-2:0], 1'b0} + {{WIDTH{1'b0}}, b_mag[bit_idx] ? a_mag : '0};

   // Restoring divide: partial remainder in the upper half, quotient shifts into the lower half.
   // A borrow out of trial[WIDTH] means the divisor did not fit.
   assign trial    = {acc[2*WIDTH-1:WIDTH], a_bit} - {1'b0, b_mag};
   assign div_step = {trial[WIDTH] ? {acc[2*WIDTH-2:WIDTH], a_bit} : trial[WIDTH-1:0],
                      acc[WIDTH-2:0], ~trial[WIDTH]};

   assign prod   = neg_q ? -acc : acc;
   assign quo    = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   assign rem    = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
   // Divide by zero reports the raw dividend in HI and all ones in LO.
   assign res_hi = !is_div ? prod[2*WIDTH-1:WIDTH] : b_zero ? a_raw : rem;
   assign res_lo = !is_div ? prod[WIDTH-1:0] : b_zero ? '1 : quo;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         op_q  <= '0;
         a_mag <= '0;
         b_mag <= '0;
         a_raw <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         acc   <= '0;
         cnt   <= '0;
         hi    <= '0;
         lo    <= '0;
         done  <= 1'b0;
      end else begin
         if (state == IDLE && start) begin
            op_q  <= op;
            a_raw <= op_a;
            a_mag <= sa ? -op_a : op_a;
            b_mag <= sb ? -op_b : op_b;
            neg_q <= sa ^ sb;
            neg_r <= sa;
            acc   <= '0;
            cnt   <= '0;
         end else if (state == CALC) begin
            acc <= is_div ? div_step : mul_step;
            cnt <= cnt + CW'(1);
         end
         if (state == FIX) begin
            hi <= res_hi;
            lo <= res_lo;
         end else if (state == IDLE && !start) begin
            if (mt_hi) hi <= op_a;
            if (mt_lo) lo <= op_a;
         end
         done <= state == FIX;
      end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed and randomized checks of mul_div_unit against an arithmetic model
module tb_mul_div_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] op_a = '0, op_b = '0;
   logic [1:0]  op = '0;
   logic        start = 1'b0, mt_hi = 1'b0, mt_lo = 1'b0;
   logic [31:0] hi, lo;
   logic        busy, done;
   int          n_cmp = 0;
   int          n_bad = 0;

   mul_div_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .op_a(op_a), .op_b(op_b), .op(op), .start(start),
      .mt_hi(mt_hi), .mt_lo(mt_lo), .hi(hi), .lo(lo), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Returns {HI, LO} from the architectural definition of each operation.
   function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (o[1] && b == 32'd0) return {a, 32'hFFFF_FFFF};
      case (o)
         2'b00: return 64'(sa * sb);
         2'b01: return {32'd0, a} * {32'd0, b};
         2'b10: begin
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         default: return {a % b, a / b};
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Issue one operation and follow it to completion. restart_at / mt_at inject a
   // start or an MTHI of 0x1234 that many cycles into the operation (-1 = never).
   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int restart_at, input int mt_at, input bit mt_with_start);
      logic [63:0] exp;
      logic [31:0] hi0, lo0;
      int busy_cnt, k;
      exp = model(o, a, b);
      @(negedge clk);
      hi0 = hi;
      lo0 = lo;
      op = o; op_a = a; op_b = b; start = 1'b1;
      mt_hi = mt_with_start; mt_lo = mt_with_start;
      @(posedge clk);
      #1;
      start = 1'b0; mt_hi = 1'b0; mt_lo = 1'b0;
      op_a = $urandom; op_b = $urandom; op = 2'($urandom);
      chk({tag, ".busy0"}, 32'(busy), 32'd1);
      if (mt_with_start) begin
         chk({tag, ".mt_start_hi"}, hi, hi0);
         chk({tag, ".mt_start_lo"}, lo, lo0);
      end
      busy_cnt = 1;
      k = 0;
      while (k < 40) begin
         if (k == restart_at) begin
            start = 1'b1; op = 2'b00; op_a = 32'd3; op_b = 32'd9;
         end
         if (k == mt_at) begin
            mt_hi = 1'b1; op_a = 32'h1234;
         end
         @(posedge clk);
         #1;
         k++;
         if (k - 1 == mt_at) chk({tag, ".mthi_busy"}, hi, hi0);
         start = 1'b0; mt_hi = 1'b0;
         if (done) break;
         busy_cnt += int'(busy);
      end
      chk({tag, ".latency"}, 32'(k), 32'd33);
      chk({tag, ".busy_cycles"}, 32'(busy_cnt), 32'd33);
      chk({tag, ".busy_end"}, 32'(busy), 32'd0);
      chk({tag, ".hi"}, hi, exp[63:32]);
      chk({tag, ".lo"}, lo, exp[31:0]);
      @(posedge clk);
      #1;
      chk({tag, ".done_pulse"}, 32'(done), 32'd0);
   endtask

   initial begin
      int dones;
      logic [1:0] ro;
      logic [31:0] ra, rb;
      #1;
      chk("reset.hi", hi, 32'd0);
      chk("reset.lo", lo, 32'd0);
      chk("reset.busy", 32'(busy), 32'd0);
      chk("reset.done", 32'(done), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, 1'b0);
      run_op("mult_neg", 2'b00, -32'sd3, 32'd5, -1, -1, 1'b0);
      run_op("div_neg", 2'b10, -32'sd7, 32'd2, -1, -1, 1'b0);
      run_op("divu_zero", 2'b11, 32'd7, 32'd0, -1, -1, 1'b0);
      run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, 1'b0);
      run_op("div_zero_neg", 2'b10, -32'sd9, 32'd0, -1, -1, 1'b0);
      run_op("divu_restart", 2'b11, 32'd100, 32'd7, 5, -1, 1'b0);
      run_op("mult_mthi_busy", 2'b00, 32'd6, -32'sd7, -1, 3, 1'b0);
      run_op("mult_mt_start", 2'b00, 32'h7FFF_FFFF, 32'h8000_0000, -1, -1, 1'b1);

      @(negedge clk);
      mt_hi = 1'b1; op_a = 32'h1234;
      @(posedge clk);
      #1;
      mt_hi = 1'b0;
      chk("mthi_idle.hi", hi, 32'h1234);
      chk("mthi_idle.lo", lo, model(2'b00, 32'h7FFF_FFFF, 32'h8000_0000) >> 0 & 64'hFFFF_FFFF);
      @(negedge clk);
      mt_hi = 1'b1; mt_lo = 1'b1; op_a = 32'hCAFE_F00D;
      @(posedge clk);
      #1;
      mt_hi = 1'b0; mt_lo = 1'b0;
      chk("mt_both.hi", hi, 32'hCAFE_F00D);
      chk("mt_both.lo", lo, 32'hCAFE_F00D);

      run_op("mult_prereset", 2'b00, 32'd12345, 32'd678, -1, -1, 1'b0);
      @(negedge clk);
      op = 2'b00; op_a = 32'h0001_0003; op_b = 32'hFFFF_0005; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("async_rst.hi", hi, 32'd0);
      chk("async_rst.lo", lo, 32'd0);
      chk("async_rst.busy", 32'(busy), 32'd0);
      chk("async_rst.done", 32'(done), 32'd0);
      #2;
      rst = 1'b0;
      dones = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         dones += int'(done);
      end
      chk("post_rst.no_done", 32'(dones), 32'd0);
      chk("post_rst.hi", hi, 32'd0);
      run_op("after_rst", 2'b01, 32'h0001_0003, 32'hFFFF_0005, -1, -1, 1'b0);

      for (int i = 0; i < 24; i++) begin
         ro = 2'($urandom);
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2: rb = 32'($urandom_range(1, 15));
            3: ra = 32'h8000_0000;
            default: ;
         endcase
         run_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, -1, -1, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers for the single-cycle MIPS core.
- Sits directly downstream of the ALU operand-B source select. It consumes the selected rs/rt operand pair and executes MULT, MULTU, DIV and DIVU over multiple cycles.
- Results are held in HI/LO for MFHI/MFLO, and MTHI/MTLO write HI/LO directly.
- Busy is the stall request to the control unit.

Parameters:
- WIDTH, 32, operand width; HI/LO are each WIDTH bits, the product is 2*WIDTH bits.

Ports:
- Clk  input  1  rising-edge clock
- Rst  input  1  asynchronous, active-high reset
- Op_A  input  WIDTH  rs operand (multiplicand / dividend)
- Op_B  input  WIDTH  rt operand from the operand-B select (multiplier / divisor)
- Op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- Start  input  1  start request, sampled only when Busy=0
- Mt_Hi  input  1  write Op_A into HI (MTHI)
- Mt_Lo  input  1  write Op_A into LO (MTLO)
- HI  output  WIDTH  HI register (product high word / remainder)
- LO  output  WIDTH  LO register (product low word / quotient)
- Busy  output  1  operation in progress; core stalls on dependent instructions
- Done  output  1  one-cycle pulse, HI/LO just updated by an operation

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - Rst=1 immediately forces HI=0, LO=0, Busy=0, Done=0, state IDLE, counter=0.
  - Reset mid-operation aborts the operation; no partial result is written.
- States: IDLE, CALC, FIX.
- IDLE, Start=1 at edge t0:
  - latch Op;
  - latch the magnitudes of Op_A/Op_B (signed ops only), plus sign of result and sign of dividend;
  - clear the 2*WIDTH accumulator and counter;
  - go to CALC; Busy=1 from t0.
- CALC: one radix-2 step per edge, WIDTH edges (counter 0..WIDTH-1).
  - Multiply: shift-add of the unsigned magnitudes.
  - Divide: restoring shift-subtract; the remainder lives in the upper half, the quotient in the lower half.
  - At counter=WIDTH-1, go to FIX.
- FIX, one edge:
  - apply sign correction;
  - write HI/LO;
  - Done=1 and Busy=0 for the following cycle;
  - go to IDLE.
- Timing: Start accepted at edge t0 → HI/LO valid and Done=1 after edge t0+WIDTH+1, i.e. 33 edges for WIDTH=32. Busy is high for exactly WIDTH+1 cycles.
- Signed multiply: the 2*WIDTH magnitude product is two's-complement negated when the operand signs differ.
- Signed divide:
  - quotient is negated when the signs differ;
  - remainder takes the sign of the dividend;
  - truncation is toward zero.
- Divide by zero (signed or unsigned): LO=all ones, HI=Op_A as latched (raw, not magnitude); no exception.
- 0x80000000 / -1 (DIV): LO=0x80000000, HI=0; no exception.
- Start while Busy=1 is ignored; the operation in flight is unaffected.
- Mt_Hi/Mt_Lo:
  - honoured only in IDLE with Start=0; HI and/or LO take Op_A at the next edge.
  - Both may be asserted together.
  - Ignored while Busy=1, and ignored when Start=1 in the same cycle (Start wins).
- Operands are not re-sampled after acceptance; Op_A/Op_B may change freely during CALC.
- HI/LO hold their value in all other cycles.

Decomposition:
- Shared package:
  - Op encoding constants OP_MULT/OP_MULTU/OP_DIV/OP_DIVU;
  - state encoding IDLE/CALC/FIX;
  - counter width $clog2(WIDTH).
- No sub-module: the datapath (accumulator, add/sub, sign fix) stays in one module with one FSM.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. Done high exactly 33 cycles after Start. Busy high for those 33 cycles only.
- MULT −3 × 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 7 / 0 → LO=0xFFFFFFFF, HI=0x00000007.
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0x00000000.
- Start=1 again at cycle 5 of a DIVU 100/7 → ignored; result LO=14, HI=2 on schedule.
- MTHI 0x1234 while Busy=1 → HI unchanged.
- MTHI 0x1234 while idle → HI=0x1234 next edge.
- Rst pulse at cycle 10 of a MULT, asynchronous to Clk → HI=LO=0, Busy=0 immediately; no Done pulse afterwards.
- New Start after that reset completes normally.
